// File: rtl/fetch_pkg.sv
// Shared types and constants for the processor Z fetch/decode front end.
// Field widths here define how an instruction word is split into icode/ifun/rA/rB/valC.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      HALTED = 2'd2
   } fetch_state_e;

   localparam int ICODE_W = 4;
   localparam int REG_W   = 4;

   localparam logic [ICODE_W-1:0] HALT_ICODE_DEFAULT = 4'h0;

endpackage

// File: rtl/fetch_if.sv
// Bundle of load, control and decoded-output signals between the fetch unit and its user.
// FETCH_BREAKPOINT_EN adds the breakpoint request/hit signals.
interface fetch_if
   import fetch_pkg::*;
#(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32
);

   logic [ADDR_W-1:0]   load_addr;
   logic                load_wr;
   logic [DATA_W-1:0]   load_wdata;
   logic                working;
   logic                stall;
   logic                redirect_valid;
   logic [ADDR_W-1:0]   redirect_pc;

   logic [ICODE_W-1:0]  icode;
   logic [ICODE_W-1:0]  ifun;
   logic [REG_W-1:0]    rA;
   logic [REG_W-1:0]    rB;
   logic [DATA_W-17:0]  valC;
   logic                instr_valid;
   logic [ADDR_W-1:0]   pc_out;
   logic                halted;

`ifdef FETCH_BREAKPOINT_EN
   logic                bp_valid;
   logic [ADDR_W-1:0]   bp_addr;
   logic                bp_hit;
`endif

   modport master (
      output load_addr, load_wr, load_wdata, working, stall, redirect_valid, redirect_pc,
`ifdef FETCH_BREAKPOINT_EN
      output bp_valid, bp_addr,
      input  bp_hit,
`endif
      input  icode, ifun, rA, rB, valC, instr_valid, pc_out, halted
   );

   modport slave (
      input  load_addr, load_wr, load_wdata, working, stall, redirect_valid, redirect_pc,
`ifdef FETCH_BREAKPOINT_EN
      input  bp_valid, bp_addr,
      output bp_hit,
`endif
      output icode, ifun, rA, rB, valC, instr_valid, pc_out, halted
   );

endinterface

// File: rtl/fetch_ram.sv
// Single-port instruction RAM with a registered read port.
// rdata only changes on a read, so it doubles as the holding register for the presented word.
module fetch_ram #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic [ADDR_W-1:0] addr,
   input  logic              wr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              rd,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

   always_ff @(posedge clock) begin
      if (wr) begin
         mem[addr] <= wdata;
      end
      if (rd) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch and decode front end: load RAM while idle, then fetch sequentially with stall/redirect/halt.
// Optional breakpoint support is compiled in with FETCH_BREAKPOINT_EN.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int                 ADDR_W     = 9,
   parameter int                 DATA_W     = 32,
   parameter logic [ADDR_W-1:0]  START_PC   = '0,
   parameter logic [ICODE_W-1:0] HALT_ICODE = HALT_ICODE_DEFAULT
) (
   input  logic clock,
   input  logic rst_n,
   fetch_if.slave bus
);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] raddr_q, raddr_d;
   logic [ADDR_W-1:0] pc_out_q, pc_out_d;
   logic              valid_q, valid_d;
   logic              live_q, live_d;

   logic              ramRd;
   logic              ramWr;
   logic [ADDR_W-1:0] ramAddr;
   logic [DATA_W-1:0] ramRdata;
   logic [DATA_W-1:0] word;
   logic              haltSeen;
   logic              issueReq;
   logic [ADDR_W-1:0] issueAddr;

`ifdef FETCH_BREAKPOINT_EN
   logic              bpPend_q, bpPend_d;
   logic              bpHit_q, bpHit_d;
`endif

   fetch_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ram (
      .clock (clock),
      .addr  (ramAddr),
      .wr    (ramWr),
      .wdata (bus.load_wdata),
      .rd    (ramRd),
      .rdata (ramRdata)
   );

   // RAM is never reset, so the fields read as zero until the first read has landed.
   assign word     = live_q ? ramRdata : '0;
   assign haltSeen = valid_q && (word[DATA_W-1 -: ICODE_W] == HALT_ICODE);

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      raddr_d   = raddr_q;
      pc_out_d  = pc_out_q;
      valid_d   = valid_q;
      live_d    = live_q;
      ramRd     = 1'b0;
      ramWr     = 1'b0;
      ramAddr   = raddr_q;
      issueReq  = 1'b0;
      issueAddr = pc_q;
`ifdef FETCH_BREAKPOINT_EN
      bpPend_d  = bpPend_q;
      bpHit_d   = bpHit_q;
`endif

      case (state_q)
         IDLE: begin
            ramAddr = bus.load_addr;
            ramWr   = bus.load_wr;
            valid_d = 1'b0;
            if (bus.working) begin
               state_d = FETCH;
               raddr_d = START_PC;
               pc_d    = START_PC + 1'b1;
            end
         end

         FETCH: begin
            if (!bus.working) begin
               state_d = IDLE;
               pc_d    = START_PC;
               valid_d = 1'b0;
`ifdef FETCH_BREAKPOINT_EN
               bpPend_d = 1'b0;
               bpHit_d  = 1'b0;
            end else if (bpPend_q) begin
               state_d  = HALTED;
               valid_d  = 1'b0;
               bpPend_d = 1'b0;
               bpHit_d  = 1'b1;
`endif
            end else if (haltSeen) begin
               state_d = HALTED;
               valid_d = 1'b0;
            end else if (bus.redirect_valid) begin
               valid_d   = 1'b0;
               issueReq  = 1'b1;
               issueAddr = bus.redirect_pc;
            end else if (!bus.stall) begin
               ramRd     = 1'b1;
               live_d    = 1'b1;
               pc_out_d  = raddr_q;
               valid_d   = 1'b1;
               issueReq  = 1'b1;
               issueAddr = pc_q;
            end
         end

         HALTED: begin
            if (!bus.working) begin
               state_d = IDLE;
               pc_d    = START_PC;
               valid_d = 1'b0;
`ifdef FETCH_BREAKPOINT_EN
               bpPend_d = 1'b0;
               bpHit_d  = 1'b0;
`endif
            end
         end

         default: begin
            state_d = IDLE;
            pc_d    = START_PC;
            valid_d = 1'b0;
         end
      endcase

      if (issueReq) begin
         raddr_d = issueAddr;
         pc_d    = issueAddr + 1'b1;
`ifdef FETCH_BREAKPOINT_EN
         // A breakpoint suppresses the read itself; the following edge parks the unit in HALTED.
         if (bus.bp_valid && (issueAddr == bus.bp_addr)) begin
            raddr_d  = raddr_q;
            pc_d     = pc_q;
            bpPend_d = 1'b1;
         end
`endif
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         pc_q     <= START_PC;
         raddr_q  <= START_PC;
         pc_out_q <= '0;
         valid_q  <= 1'b0;
         live_q   <= 1'b0;
`ifdef FETCH_BREAKPOINT_EN
         bpPend_q <= 1'b0;
         bpHit_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         raddr_q  <= raddr_d;
         pc_out_q <= pc_out_d;
         valid_q  <= valid_d;
         live_q   <= live_d;
`ifdef FETCH_BREAKPOINT_EN
         bpPend_q <= bpPend_d;
         bpHit_q  <= bpHit_d;
`endif
      end
   end

   assign bus.icode       = word[DATA_W-1  -: ICODE_W];
   assign bus.ifun        = word[DATA_W-5  -: ICODE_W];
   assign bus.rA          = word[DATA_W-9  -: REG_W];
   assign bus.rB          = word[DATA_W-13 -: REG_W];
   assign bus.valC        = word[DATA_W-17:0];
   assign bus.instr_valid = valid_q;
   assign bus.pc_out      = pc_out_q;
   assign bus.halted      = (state_q == HALTED);
`ifdef FETCH_BREAKPOINT_EN
   assign bus.bp_hit      = bpHit_q;
`endif

endmodule
